// File: rtl/cv32e40p_pkg.sv
// Shared types for the TMR mismatch logger.
package cv32e40p_pkg;

    localparam int unsigned TMR_NUM_REPLICAS = 3;

    // Fault classification code stored in each log entry.
    typedef enum logic [1:0] {
        TMR_REP0,
        TMR_REP1,
        TMR_REP2,
        TMR_UNCORR
    } tmr_fault_e;

    // Resync handshake state.
    typedef enum logic [0:0] {
        TMR_RS_IDLE,
        TMR_RS_REQ
    } tmr_resync_state_e;

endpackage

// File: rtl/cv32e40p_tmr_log_fifo.sv
// First-word fall-through FIFO for fault log entries.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cv32e40p_tmr_log_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en, pop_en;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);
    // Head is forced to zero when empty so stale data never shows on the outputs.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_en && !pop_en)      count_d = count_q + 1'b1;
            else if (pop_en && !push_en) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cv32e40p_tmr_mismatch_logger.sv
// Classifies TMR replica disagreements, logs them with a timestamp and
// requests a resync of any replica whose error count reaches THRESH.
module cv32e40p_tmr_mismatch_logger
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter int unsigned TS_WIDTH   = 16,
    parameter int unsigned THRESH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] res0_i,
    input  logic [DATA_WIDTH-1:0] res1_i,
    input  logic [DATA_WIDTH-1:0] res2_i,
    input  logic                  clear_i,
    input  logic                  log_rd_i,
    output logic                  log_valid_o,
    output logic [1:0]            log_replica_o,
    output logic [TS_WIDTH-1:0]   log_ts_o,
    output logic [DATA_WIDTH-1:0] log_syndrome_o,
    output logic                  overflow_o,
    output logic                  uncorrectable_o,
    output logic [CNT_WIDTH-1:0]  err_cnt0_o,
    output logic [CNT_WIDTH-1:0]  err_cnt1_o,
    output logic [CNT_WIDTH-1:0]  err_cnt2_o,
    output logic                  resync_req_o,
    output logic [1:0]            resync_id_o,
    input  logic                  resync_ack_i
);

    localparam int unsigned ENTRY_W = 2 + TS_WIDTH + DATA_WIDTH;

    logic [TS_WIDTH-1:0]   ts_q;
    tmr_fault_e            fault_code;
    logic [2:0]            fault_hit;
    logic [DATA_WIDTH-1:0] syndrome;
    logic                  any_diff, log_event;
    logic                  eq01, eq02, eq12;

    logic [CNT_WIDTH-1:0]  err_cnt_q [TMR_NUM_REPLICAS];
    logic [CNT_WIDTH-1:0]  err_cnt_d [TMR_NUM_REPLICAS];
    logic [2:0]            thr_hit;

    tmr_resync_state_e     state_q, state_d;
    logic [1:0]            resync_id_q, resync_id_d;
    logic                  ack_fire;

    logic                  overflow_q, overflow_d;
    logic                  uncorr_q, uncorr_d;

    logic [ENTRY_W-1:0]    push_entry, head_entry;
    logic                  fifo_full, fifo_empty, fifo_pop;

    assign eq01 = (res0_i == res1_i);
    assign eq02 = (res0_i == res2_i);
    assign eq12 = (res1_i == res2_i);

    // Classify the replica triple; the two agreeing replicas form the majority.
    always_comb begin
        fault_code = TMR_REP0;
        fault_hit  = '0;
        syndrome   = '0;
        any_diff   = !(eq01 && eq02);
        if (!any_diff) begin
            fault_code = TMR_REP0;
        end else if (eq12) begin
            fault_code   = TMR_REP0;
            fault_hit[0] = 1'b1;
            syndrome     = res0_i ^ res1_i;
        end else if (eq02) begin
            fault_code   = TMR_REP1;
            fault_hit[1] = 1'b1;
            syndrome     = res1_i ^ res0_i;
        end else if (eq01) begin
            fault_code   = TMR_REP2;
            fault_hit[2] = 1'b1;
            syndrome     = res2_i ^ res0_i;
        end else begin
            fault_code = TMR_UNCORR;
            syndrome   = '1;
        end
    end

    // clear_i discards any event arriving in the same cycle.
    assign log_event  = valid_i && any_diff && !clear_i;
    assign fifo_pop   = log_rd_i && !fifo_empty;
    assign push_entry = {fault_code, ts_q, syndrome};

    // Free-running timestamp; not affected by clear_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    cv32e40p_tmr_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_log_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear_i),
        .push_i  (log_event),
        .data_i  (push_entry),
        .pop_i   (log_rd_i),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign log_valid_o    = !fifo_empty;
    assign log_replica_o  = head_entry[ENTRY_W-1 -: 2];
    assign log_ts_o       = head_entry[DATA_WIDTH +: TS_WIDTH];
    assign log_syndrome_o = head_entry[DATA_WIDTH-1:0];

    // Saturating per-replica counters; an acknowledged resync clears its counter
    // even if that replica faults in the same cycle.
    always_comb begin
        for (int k = 0; k < TMR_NUM_REPLICAS; k++) begin
            err_cnt_d[k] = err_cnt_q[k];
            if (log_event && fault_hit[k] && (err_cnt_q[k] != '1)) begin
                err_cnt_d[k] = err_cnt_q[k] + 1'b1;
            end
            if (ack_fire && (resync_id_q == 2'(k))) err_cnt_d[k] = '0;
            if (clear_i) err_cnt_d[k] = '0;
            thr_hit[k] = (err_cnt_q[k] >= CNT_WIDTH'(THRESH));
        end
    end

    // Resync handshake next-state; lowest over-threshold replica is served first.
    always_comb begin
        state_d     = state_q;
        resync_id_d = resync_id_q;
        ack_fire    = 1'b0;
        case (state_q)
            TMR_RS_IDLE: begin
                if (|thr_hit) begin
                    state_d     = TMR_RS_REQ;
                    resync_id_d = thr_hit[0] ? 2'd0 : (thr_hit[1] ? 2'd1 : 2'd2);
                end
            end
            TMR_RS_REQ: begin
                if (resync_ack_i) begin
                    ack_fire = 1'b1;
                    state_d  = TMR_RS_IDLE;
                end
            end
            default: state_d = TMR_RS_IDLE;
        endcase
        if (clear_i) begin
            state_d     = TMR_RS_IDLE;
            resync_id_d = '0;
            ack_fire    = 1'b0;
        end
    end

    // Sticky flags next-state.
    always_comb begin
        overflow_d = overflow_q | (log_event && fifo_full && !fifo_pop);
        uncorr_d   = uncorr_q | (log_event && (fault_code == TMR_UNCORR));
        if (clear_i) begin
            overflow_d = 1'b0;
            uncorr_d   = 1'b0;
        end
    end

    // Counter, FSM and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TMR_NUM_REPLICAS; k++) err_cnt_q[k] <= '0;
            state_q     <= TMR_RS_IDLE;
            resync_id_q <= '0;
            overflow_q  <= 1'b0;
            uncorr_q    <= 1'b0;
        end else begin
            for (int k = 0; k < TMR_NUM_REPLICAS; k++) err_cnt_q[k] <= err_cnt_d[k];
            state_q     <= state_d;
            resync_id_q <= resync_id_d;
            overflow_q  <= overflow_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign err_cnt0_o      = err_cnt_q[0];
    assign err_cnt1_o      = err_cnt_q[1];
    assign err_cnt2_o      = err_cnt_q[2];
    assign overflow_o      = overflow_q;
    assign uncorrectable_o = uncorr_q;
    assign resync_req_o    = (state_q == TMR_RS_REQ);
    assign resync_id_o     = resync_id_q;

endmodule

// File: tb/tb_cv32e40p_tmr_mismatch_logger.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_cv32e40p_tmr_mismatch_logger;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam int THR = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, clear_i, log_rd_i, resync_ack_i;
    logic [DW-1:0] res0_i, res1_i, res2_i;
    logic          log_valid_o, overflow_o, uncorrectable_o, resync_req_o;
    logic [1:0]    log_replica_o, resync_id_o;
    logic [TW-1:0] log_ts_o;
    logic [DW-1:0] log_syndrome_o;
    logic [CW-1:0] err_cnt0_o, err_cnt1_o, err_cnt2_o;

    cv32e40p_tmr_mismatch_logger #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW),
        .TS_WIDTH   (TW),
        .THRESH     (THR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .res0_i          (res0_i),
        .res1_i          (res1_i),
        .res2_i          (res2_i),
        .clear_i         (clear_i),
        .log_rd_i        (log_rd_i),
        .log_valid_o     (log_valid_o),
        .log_replica_o   (log_replica_o),
        .log_ts_o        (log_ts_o),
        .log_syndrome_o  (log_syndrome_o),
        .overflow_o      (overflow_o),
        .uncorrectable_o (uncorrectable_o),
        .err_cnt0_o      (err_cnt0_o),
        .err_cnt1_o      (err_cnt1_o),
        .err_cnt2_o      (err_cnt2_o),
        .resync_req_o    (resync_req_o),
        .resync_id_o     (resync_id_o),
        .resync_ack_i    (resync_ack_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          rep;
        int          ts;
        logic [31:0] syn;
    } entry_t;

    entry_t m_q[$];
    int     m_cnt[3];
    bit     m_ovf, m_unc, m_req;
    int     m_id, m_ts;

    task automatic model_reset();
        m_q.delete();
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        m_ovf = 0; m_unc = 0; m_req = 0; m_id = 0; m_ts = 0;
    endtask

    // One clock edge worth of behaviour, from the inputs applied before the edge.
    task automatic model_edge();
        int          pre_cnt[3];
        bit          pre_req, pop, ev;
        int          rep;
        logic [31:0] maj, syn;
        logic [31:0] r[3];
        entry_t      e;
        r[0] = res0_i; r[1] = res1_i; r[2] = res2_i;
        for (int k = 0; k < 3; k++) pre_cnt[k] = m_cnt[k];
        pre_req = m_req;
        pop = log_rd_i && (m_q.size() > 0);
        ev = 0; rep = 0; syn = '0;
        maj = (r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]);
        if (valid_i && !(r[0] == r[1] && r[1] == r[2])) begin
            ev = 1; rep = 3; syn = 32'hFFFF_FFFF;
            for (int k = 0; k < 3; k++)
                if (r[(k+1)%3] == r[(k+2)%3]) begin
                    rep = k;
                    syn = r[k] ^ maj;
                end
        end
        if (clear_i) begin
            m_q.delete();
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
            m_ovf = 0; m_unc = 0; m_req = 0; m_id = 0;
        end else begin
            if (ev && rep < 3 && m_cnt[rep] < CMAX) m_cnt[rep]++;
            if (ev && rep == 3) m_unc = 1;
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (m_q.size() < DEPTH) begin
                    e.rep = rep; e.ts = m_ts; e.syn = syn;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
            if (pre_req) begin
                if (resync_ack_i) begin
                    m_cnt[m_id] = 0;
                    m_req = 0;
                end
            end else begin
                for (int k = 2; k >= 0; k--)
                    if (pre_cnt[k] >= THR) begin
                        m_req = 1;
                        m_id = k;
                    end
            end
        end
        m_ts = (m_ts + 1) % (1 << TW);
    endtask

    task automatic compare_all();
        check_val("log_valid", 64'(log_valid_o), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check_val("log_replica", 64'(log_replica_o), 64'(m_q[0].rep));
            check_val("log_ts", 64'(log_ts_o), 64'(m_q[0].ts));
            check_val("log_syndrome", 64'(log_syndrome_o), 64'(m_q[0].syn));
        end
        check_val("overflow", 64'(overflow_o), 64'(m_ovf));
        check_val("uncorrectable", 64'(uncorrectable_o), 64'(m_unc));
        check_val("err_cnt0", 64'(err_cnt0_o), 64'(m_cnt[0]));
        check_val("err_cnt1", 64'(err_cnt1_o), 64'(m_cnt[1]));
        check_val("err_cnt2", 64'(err_cnt2_o), 64'(m_cnt[2]));
        check_val("resync_req", 64'(resync_req_o), 64'(m_req));
        if (m_req) check_val("resync_id", 64'(resync_id_o), 64'(m_id));
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_log_valid"}, 64'(log_valid_o), 64'd0);
        check_val({tag, "_replica"}, 64'(log_replica_o), 64'd0);
        check_val({tag, "_ts"}, 64'(log_ts_o), 64'd0);
        check_val({tag, "_syndrome"}, 64'(log_syndrome_o), 64'd0);
        check_val({tag, "_overflow"}, 64'(overflow_o), 64'd0);
        check_val({tag, "_uncorr"}, 64'(uncorrectable_o), 64'd0);
        check_val({tag, "_cnt"}, 64'({err_cnt0_o, err_cnt1_o, err_cnt2_o}), 64'd0);
        check_val({tag, "_req"}, 64'(resync_req_o), 64'd0);
        check_val({tag, "_id"}, 64'(resync_id_o), 64'd0);
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit rd, input bit ack, input bit clr);
        valid_i = v; res0_i = a; res1_i = b; res2_i = c;
        log_rd_i = rd; resync_ack_i = ack; clear_i = clr;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    task automatic clear_step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
    endtask

    function automatic logic [31:0] nz_mask();
        logic [31:0] m;
        m = $urandom();
        if (m == 0) m = 32'h1;
        return m;
    endfunction

    initial begin
        int          pops;
        logic [31:0] base, m1, m2;
        int          kind, k;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Single fault on replica 1 at timestamp 5.
        repeat (5) idle_step();
        drive(1, 32'h0, 32'h0000_00F0, 32'h0, 0, 0, 0);
        step();
        check_val("t2_replica", 64'(log_replica_o), 64'd1);
        check_val("t2_ts", 64'(log_ts_o), 64'd5);
        check_val("t2_syndrome", 64'(log_syndrome_o), 64'h0000_00F0);
        check_val("t2_cnt1", 64'(err_cnt1_o), 64'd1);
        idle_step();

        // All replicas agree for 10 cycles.
        clear_step();
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 0, 0, 0);
            step();
        end
        check_val("t1_log_valid", 64'(log_valid_o), 64'd0);
        check_val("t1_req", 64'(resync_req_o), 64'd0);

        // Three-way disagreement, then clear.
        drive(1, 32'd1, 32'd2, 32'd3, 0, 0, 0);
        step();
        check_val("t3_replica", 64'(log_replica_o), 64'd3);
        check_val("t3_syndrome", 64'(log_syndrome_o), 64'hFFFF_FFFF);
        check_val("t3_uncorr", 64'(uncorrectable_o), 64'd1);
        check_val("t3_cnt", 64'({err_cnt0_o, err_cnt1_o, err_cnt2_o}), 64'd0);
        clear_step();
        check_val("t3_clr_uncorr", 64'(uncorrectable_o), 64'd0);
        check_val("t3_clr_valid", 64'(log_valid_o), 64'd0);

        // Overflow: five replica-2 faults into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) begin
            base = $urandom();
            drive(1, base, base, base ^ nz_mask(), 0, 0, 0);
            step();
        end
        check_val("t4_overflow", 64'(overflow_o), 64'd1);
        base = $urandom();
        drive(1, base, base, base ^ nz_mask(), 1, 0, 0);
        step();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (!log_valid_o) break;
            drive(0, 0, 0, 0, 1, 0, 0);
            step();
            pops++;
        end
        check_val("t4_depth", 64'(pops), 64'(DEPTH));
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        clear_step();

        // Resync handshake on replica 0.
        for (int i = 0; i < 4; i++) begin
            base = $urandom();
            drive(1, base ^ nz_mask(), base, base, 0, 0, 0);
            step();
        end
        idle_step();
        check_val("t5_req", 64'(resync_req_o), 64'd1);
        check_val("t5_id", 64'(resync_id_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle_step();
            check_val("t5_req_hold", 64'(resync_req_o), 64'd1);
            check_val("t5_id_hold", 64'(resync_id_o), 64'd0);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        check_val("t5_cnt0_cleared", 64'(err_cnt0_o), 64'd0);
        check_val("t5_req_low", 64'(resync_req_o), 64'd0);
        clear_step();

        // Reset in the middle of a handshake with two entries logged.
        for (int i = 0; i < 4; i++) begin
            base = $urandom();
            drive(1, base ^ nz_mask(), base, base, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        check_val("t6_pre_req", 64'(resync_req_o), 64'd1);
        check_val("t6_pre_valid", 64'(log_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 32'h0, 32'h5, 32'h0, 0, 0, 0);
        step();
        check_val("t6_ts_restart", 64'(log_ts_o), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            base = $urandom();
            m1 = nz_mask();
            m2 = nz_mask();
            if (m2 == m1) m2 = m1 ^ 32'h8000_0000;
            kind = $urandom_range(0, 9);
            k = $urandom_range(0, 2);
            valid_i = ($urandom_range(0, 9) < 7);
            res0_i = base; res1_i = base; res2_i = base;
            if (kind >= 5 && kind <= 8) begin
                if (k == 0) res0_i = base ^ m1;
                else if (k == 1) res1_i = base ^ m1;
                else res2_i = base ^ m1;
            end else if (kind == 9) begin
                res1_i = base ^ m1;
                res2_i = base ^ m2;
            end
            log_rd_i = $urandom_range(0, 1);
            resync_ack_i = ($urandom_range(0, 2) == 0);
            clear_i = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
